// File: rtl/csa_mult_pkg.sv
// Shared definitions for the carry-save sequential multiplier controller.
package csa_mult_pkg;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Bits needed to index one multiplier bit; at least one bit wide.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/csa_fa.sv
// Single full-adder cell: sum = x^y^z, carry = majority(x, y, z).
module csa_fa (
  input  logic x_i,
  input  logic y_i,
  input  logic z_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = x_i ^ y_i ^ z_i;
  assign c_o = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);

endmodule

// File: rtl/csa_row.sv
// One row of WIDTH independent full-adder cells (3:2 compressor), purely combinational.
// Carries come out at the same bit index as their inputs; any weighting shift is up to the user.
module csa_row #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] z_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] c_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    csa_fa u_fa (
      .x_i (x_i[i]),
      .y_i (y_i[i]),
      .z_i (z_i[i]),
      .s_o (s_o[i]),
      .c_o (c_o[i])
    );
  end

endmodule

// File: rtl/csa_seq_mult_ctrl.sv
// Sequential unsigned multiplier: one carry-save row reused for WIDTH cycles, then a single
// carry-propagate add resolves the upper half. Start/done handshake toward the issuer.
module csa_seq_mult_ctrl
  import csa_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e              state_q, state_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic [WIDTH-1:0]    carry_q, carry_d;
  logic [WIDTH-1:0]    low_q, low_d;
  logic [2*WIDTH-1:0]  product_q, product_d;
  logic                done_q, done_d;

  logic [WIDTH-1:0]    pp;
  logic [WIDTH-1:0]    row_s;
  logic [WIDTH-1:0]    row_c;
  logic [WIDTH-1:0]    high;

  // Partial product for the multiplier bit selected by the cycle counter.
  assign pp = a_q & {WIDTH{b_q[count_q]}};

  // Final carry-propagate add; modulo 2^WIDTH is exact since the product fits in 2*WIDTH bits.
  assign high = sum_q + carry_q;

  csa_row #(
    .WIDTH (WIDTH)
  ) u_row (
    .x_i (sum_q),
    .y_i (carry_q),
    .z_i (pp),
    .s_o (row_s),
    .c_o (row_c)
  );

  // Next-state and datapath update for each controller state.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    low_d     = low_q;
    product_d = product_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          sum_d   = '0;
          carry_d = '0;
          low_d   = '0;
          count_d = '0;
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        // Retire the settled LSB; the rest of the sum moves up one weight. Carries already
        // sit one weight above their cell, so they are kept unshifted.
        low_d[count_q] = row_s[0];
        sum_d          = {1'b0, row_s[WIDTH-1:1]};
        carry_d        = row_c;
        count_d        = count_q + 1'b1;
        if (count_q == LastCnt) begin
          state_d = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        product_d = {high, low_q};
        done_d    = 1'b1;
        state_d   = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
      low_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      low_q     <= low_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign ready_o   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy_o    = (state_q == ST_ACCUM) || (state_q == ST_RESOLVE);
  assign done_o    = done_q;
  assign product_o = product_q;

endmodule

// File: doc/csa_seq_mult_ctrl.md
Name: csa_seq_mult_ctrl

Overview:
- Sequential unsigned multiplier controller.
- Time-shares one row of WIDTH carry-save full-adder cells (A^B^Cin / majority) across WIDTH cycles to accumulate partial products.
- Resolves the sum/carry pair with a final carry-propagate add in one cycle.
- Area-reduced alternative to the full Dadda tree in the multiplier datapath.
- Start/done handshake to the issuing unit.

Parameters:
- WIDTH, 8, operand width in bits (≥2); product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  request; sampled only when ready=1
- a  input  WIDTH  multiplicand; latched on accepted start
- b  input  WIDTH  multiplier; latched on accepted start
- ready  output  1  high in IDLE and DONE (can accept start)
- busy  output  1  high in ACCUM and RESOLVE
- done  output  1  one-cycle pulse: product valid
- product  output  2*WIDTH  result; held until next RESOLVE completes

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, count=0.
  - sum/carry/low/operand registers = 0.
  - product=0, done=0, busy=0, ready=1.
- States and transitions:
  - IDLE: start=1 → latch a, b; clear sum/carry/low; count=0; go to ACCUM.
  - ACCUM: each edge:
    - pp = a_q & {WIDTH{b_q[count]}}.
    - csa_row(sum, carry, pp) → s', c'.
    - low[count] <= s'[0]; sum <= {1'b0, s'[WIDTH-1:1]}; carry <= c'.
    - count++. At count==WIDTH-1 → RESOLVE.
    - Exactly WIDTH accumulate edges.
  - RESOLVE: one edge.
    - product <= {(sum+carry)[WIDTH-1:0], low}.
    - done <= 1; go to DONE.
  - DONE: done=1 for this single cycle.
    - start=1 → accepted exactly as in IDLE; back-to-back operation, no bubble.
    - else → IDLE.
- Latency: start accepted at edge E0; product and done valid after edge E0+WIDTH+1. Throughput: one result per WIDTH+2 cycles.
- Width rule: the high-half add is modulo 2^WIDTH. The true result is < 2^(2*WIDTH), so no overflow is lost.
- Boundary conditions:
  - start while busy: ignored. No queuing, operands unchanged.
  - a or b changing after acceptance: no effect.
  - rst_n low mid-ACCUM/RESOLVE: immediate abort to reset values. No done, product cleared.
  - b=0 or a=0: full WIDTH cycles still run; product=0.
  - start held high continuously: a new operation begins in every DONE cycle.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Decomposition:
- Shared package csa_mult_pkg:
  - state encoding constants ST_IDLE, ST_ACCUM, ST_RESOLVE, ST_DONE (2-bit).
  - counter-width helper (clog2 of WIDTH).
- Sub-module csa_row:
  - WIDTH parallel instances of the existing full-adder cell.
  - inputs x, y, z[WIDTH]; outputs s[WIDTH], c[WIDTH].
  - purely combinational.
  - c is routed unshifted into the carry register; the shift is applied to s only.

Test Plan:
- WIDTH=8, a=255, b=255, start one cycle → done exactly 9 edges after accept, product=16'hFE01; busy high for 9 cycles.
- WIDTH=8, a=0x5A, b=0x00 → product=0 after 9 cycles. Then a=0x01, b=0x80 → product=16'h0080.
- Start re-asserted with a=3, b=3 during ACCUM of a=12, b=10 → ignored; product=120, only one done pulse.
- rst_n pulled low at accumulate cycle 4 of a=200, b=100 → outputs zero immediately; a new start afterwards yields 20000 correctly.
- start held high, operand pairs (7,9), (255,2), (128,128) back-to-back → done pulses spaced 10 cycles apart; products 63, 510, 16384.
- WIDTH=4 build, exhaustive 16x16 operand sweep → every product equals a*b; done latency 5 edges.
